// File: rtl/cw305_usb_pkg.sv
// Shared definitions for the CW305 USB bus responder: FSM encoding and data width.
package cw305_usb_pkg;

  localparam int unsigned DataWidth = 8;

  typedef enum logic [2:0] {
    StIdle,
    StWrArm,
    StWrDone,
    StRdLaunch,
    StRdHold
  } state_e;

endpackage

// File: rtl/cw305_usb_bus_responder_if.sv
// Host bus and register-bank signals of the CW305 USB responder.
// master: host/register-bank side, slave: the responder itself.
interface cw305_usb_bus_responder_if #(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7
);
  import cw305_usb_pkg::*;

  logic [pADDR_WIDTH-1:0]               usb_addr;
  logic [DataWidth-1:0]                 usb_din;
  logic                                 usb_rdn;
  logic                                 usb_wrn;
  logic                                 usb_cen;
  logic [DataWidth-1:0]                 read_data;
  logic [DataWidth-1:0]                 usb_dout;
  logic                                 usb_isout;
  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address;
  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt;
  logic [DataWidth-1:0]                 write_data;
  logic                                 reg_write;
  logic                                 reg_read;
  logic                                 reg_addrvalid;
  logic [7:0]                           error_count;

  modport master (
    output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, read_data,
    input  usb_dout, usb_isout, reg_address, reg_bytecnt, write_data,
           reg_write, reg_read, reg_addrvalid, error_count
  );

  modport slave (
    input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen, read_data,
    output usb_dout, usb_isout, reg_address, reg_bytecnt, write_data,
           reg_write, reg_read, reg_addrvalid, error_count
  );

endinterface

// File: rtl/cw305_usb_strobe_decode.sv
// Registers the active-low host strobes and decodes the transaction events.
// New transactions are only allowed once the bus has been seen idle (rdn and wrn
// both high) after reset, so a transaction cut by reset is never resumed.
module cw305_usb_strobe_decode (
  input  logic clk,
  input  logic rst_n,
  input  logic rdn,
  input  logic wrn,
  input  logic cen,
  output logic wr_arm,
  output logic wr_commit,
  output logic rd_start,
  output logic violation,
  output logic wr_high,
  output logic rd_high
);

  logic rdn_q, wrn_q, cen_q;
  logic bus_seen_q;

  // Sample strobes; remember whether the bus has been idle since reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdn_q      <= 1'b1;
      wrn_q      <= 1'b1;
      cen_q      <= 1'b1;
      bus_seen_q <= 1'b0;
    end else begin
      rdn_q      <= rdn;
      wrn_q      <= wrn;
      cen_q      <= cen;
      bus_seen_q <= bus_seen_q | (rdn & wrn);
    end
  end

  // Event decode from the sampled strobes.
  always_comb begin
    wr_arm    = bus_seen_q & ~wrn_q & rdn_q;
    wr_commit = ~wrn_q & rdn_q & ~cen_q;
    rd_start  = bus_seen_q & ~rdn_q & wrn_q & ~cen_q;
    violation = ~rdn_q & ~wrn_q;
    wr_high   = wrn_q;
    rd_high   = rdn_q;
  end

endmodule

// File: rtl/cw305_usb_bus_responder.sv
// CW305 USB bus responder: turns host rdn/wrn/cen strobes into single-cycle
// register-bank read/write strobes with a latched address.
// Optional feature: define USB_RESP_ERRCNT_EN to count rdn/wrn-both-low
// violations in a saturating 8-bit counter; otherwise error_count is 0.
module cw305_usb_bus_responder
  import cw305_usb_pkg::*;
#(
  parameter int unsigned pADDR_WIDTH   = 21,
  parameter int unsigned pBYTECNT_SIZE = 7
) (
  input logic                       usb_clk,
  input logic                       rst_n,
  cw305_usb_bus_responder_if.slave  bus
);

  localparam int unsigned RegAddrWidth = pADDR_WIDTH - pBYTECNT_SIZE;

  logic wr_arm, wr_commit, rd_start, violation, wr_high, rd_high;

  state_e state_q, state_d;

  logic                     write_stb, read_stb, latch_en, dout_en, isout;
  logic                     reg_write_q, reg_read_q, addrvalid_q;
  logic [RegAddrWidth-1:0]  addr_q;
  logic [pBYTECNT_SIZE-1:0] bytecnt_q;
  logic [DataWidth-1:0]     wdata_q, dout_q;

  cw305_usb_strobe_decode u_decode (
    .clk       (usb_clk),
    .rst_n     (rst_n),
    .rdn       (bus.usb_rdn),
    .wrn       (bus.usb_wrn),
    .cen       (bus.usb_cen),
    .wr_arm    (wr_arm),
    .wr_commit (wr_commit),
    .rd_start  (rd_start),
    .violation (violation),
    .wr_high   (wr_high),
    .rd_high   (rd_high)
  );

  // FSM state register.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a violation always drops back to idle.
  always_comb begin
    state_d = state_q;
    if (violation) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rd_start) begin
            state_d = StRdLaunch;
          end else if (wr_arm) begin
            state_d = StWrArm;
          end
        end
        StWrArm: begin
          if (wr_high) begin
            state_d = StIdle;
          end else if (wr_commit) begin
            state_d = StWrDone;
          end
        end
        StWrDone: begin
          if (wr_high) begin
            state_d = StIdle;
          end
        end
        StRdLaunch: state_d = StRdHold;
        StRdHold: begin
          if (rd_high) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output decode from the current/next state.
  always_comb begin
    write_stb = (state_q == StWrArm) && (state_d == StWrDone);
    read_stb  = (state_q == StIdle) && (state_d == StRdLaunch);
    latch_en  = write_stb | read_stb;
    dout_en   = (state_q == StRdLaunch);
    // Pad drive is suppressed whenever wrn is sampled low.
    isout     = ((state_q == StRdLaunch) || (state_q == StRdHold)) && wr_high;
  end

  // Registered strobes and datapath latches.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      reg_read_q  <= 1'b0;
      addrvalid_q <= 1'b0;
      addr_q      <= '0;
      bytecnt_q   <= '0;
      wdata_q     <= '0;
      dout_q      <= '0;
    end else begin
      reg_write_q <= write_stb;
      reg_read_q  <= read_stb;
      addrvalid_q <= (state_d == StWrDone) || (state_d == StRdLaunch) || (state_d == StRdHold);
      if (latch_en) begin
        addr_q    <= bus.usb_addr[pADDR_WIDTH-1:pBYTECNT_SIZE];
        bytecnt_q <= bus.usb_addr[pBYTECNT_SIZE-1:0];
      end
      if (write_stb) begin
        wdata_q <= bus.usb_din;
      end
      if (dout_en) begin
        dout_q <= bus.read_data;
      end
    end
  end

`ifdef USB_RESP_ERRCNT_EN
  logic [7:0] err_q;

  // Saturating protocol-violation counter.
  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 8'h00;
    end else if (violation && (err_q != 8'hFF)) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign bus.error_count = err_q;
`else
  assign bus.error_count = 8'h00;
`endif

  assign bus.usb_dout      = dout_q;
  assign bus.usb_isout     = isout;
  assign bus.reg_address   = addr_q;
  assign bus.reg_bytecnt   = bytecnt_q;
  assign bus.write_data    = wdata_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.reg_read      = reg_read_q;
  assign bus.reg_addrvalid = addrvalid_q;

endmodule

// File: tb/tb_cw305_usb_bus_responder.sv
// Directed bench for cw305_usb_bus_responder: writes, reads, back-to-back
// writes, strobe violations and mid-transaction reset.
module tb_cw305_usb_bus_responder;

  typedef struct packed {
    logic [13:0] addr;
    logic [6:0]  sub;
    logic [7:0]  data;
  } wr_rec_t;

`ifdef USB_RESP_ERRCNT_EN
  localparam logic [7:0] ErrAfterOne = 8'd3;
  localparam logic [7:0] ErrAfterAll = 8'hFF;
`else
  localparam logic [7:0] ErrAfterOne = 8'd0;
  localparam logic [7:0] ErrAfterAll = 8'd0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_bad;
  int   rd_cnt;
  int   wr_before;
  int   rd_before;
  wr_rec_t wr_log[$];

  cw305_usb_bus_responder_if #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) bus ();

  cw305_usb_bus_responder #(.pADDR_WIDTH(21), .pBYTECNT_SIZE(7)) dut (
    .usb_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  // Small register bank: only reg 0x05 byte 0 holds a distinctive value.
  assign bus.read_data = (bus.reg_address == 14'h5 && bus.reg_bytecnt == 7'd0) ? 8'h3C : 8'hEE;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (bus.reg_write) wr_log.push_back({bus.reg_address, bus.reg_bytecnt, bus.write_data});
    if (bus.reg_read) rd_cnt = rd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [13:0] ra, input logic [6:0] sb, input logic [7:0] d,
                           input bit repulse);
    bus.usb_addr = {ra, sb};
    bus.usb_din  = d;
    bus.usb_wrn  = 1'b0;
    tick();
    tick();
    bus.usb_cen = 1'b0;
    tick();
    tick();
    bus.usb_cen = 1'b1;
    tick();
    if (repulse) begin
      bus.usb_cen = 1'b0;
      tick();
      tick();
      tick();
      bus.usb_cen = 1'b1;
      tick();
    end
    bus.usb_wrn = 1'b1;
    tick();
    tick();
    tick();
  endtask

  function automatic logic [63:0] all_outs();
    return {15'd0, bus.usb_dout, bus.usb_isout, bus.reg_address, bus.reg_bytecnt,
            bus.write_data, bus.reg_write, bus.reg_read, bus.reg_addrvalid, bus.error_count};
  endfunction

  initial begin
    n_checks = 0;
    n_bad    = 0;
    rd_cnt   = 0;
    rst_n        = 1'b0;
    bus.usb_addr = '0;
    bus.usb_din  = '0;
    bus.usb_rdn  = 1'b1;
    bus.usb_wrn  = 1'b1;
    bus.usb_cen  = 1'b1;
    tick();
    tick();
    check_eq("reset_state", all_outs(), 64'd0);
    rst_n = 1'b1;
    tick();
    tick();

    // Single write: reg 0x05, subbyte 3, data 0xA5.
    bus_write(14'h5, 7'd3, 8'hA5, 1'b0);
    check_eq("wr_count", wr_log.size(), 1);
    if (wr_log.size() > 0) check_eq("wr_fields", wr_log[0], {14'h5, 7'd3, 8'hA5});
    check_eq("wr_addrvalid_idle", bus.reg_addrvalid, 1'b0);

    // cen re-pulse while in WR_DONE must not commit twice.
    bus_write(14'h5, 7'd4, 8'h5A, 1'b1);
    check_eq("wr_repulse_count", wr_log.size(), 2);

    // Write abort: wrn returns high without any cen pulse.
    bus.usb_addr = {14'h9, 7'd1};
    bus.usb_wrn  = 1'b0;
    tick();
    tick();
    tick();
    bus.usb_wrn = 1'b1;
    tick();
    tick();
    tick();
    check_eq("wr_abort_count", wr_log.size(), 2);

    // Read: reg 0x05, subbyte 0.
    bus.usb_addr = {14'h5, 7'd0};
    bus.usb_rdn  = 1'b0;
    bus.usb_cen  = 1'b0;
    tick();
    tick();
    check_eq("rd_strobe", bus.reg_read, 1'b1);
    check_eq("rd_isout_launch", bus.usb_isout, 1'b1);
    check_eq("rd_addrvalid", bus.reg_addrvalid, 1'b1);
    check_eq("rd_address", {bus.reg_address, bus.reg_bytecnt}, {14'h5, 7'd0});
    tick();
    check_eq("rd_dout", bus.usb_dout, 8'h3C);
    check_eq("rd_isout_hold", bus.usb_isout, 1'b1);
    check_eq("rd_strobe_single", bus.reg_read, 1'b0);
    bus.usb_rdn = 1'b1;
    bus.usb_cen = 1'b1;
    tick();
    tick();
    check_eq("rd_isout_done", bus.usb_isout, 1'b0);
    check_eq("rd_addrvalid_done", bus.reg_addrvalid, 1'b0);
    check_eq("rd_dout_held", bus.usb_dout, 8'h3C);
    check_eq("rd_count", rd_cnt, 1);

    // Back-to-back: 16 writes to reg 0x02, subbytes 0..15.
    wr_log.delete();
    for (int i = 0; i < 16; i++) begin
      bus_write(14'h2, 7'(i), 8'(8'h10 + i), 1'b0);
    end
    check_eq("b2b_count", wr_log.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (i < wr_log.size()) check_eq("b2b_entry", wr_log[i], {14'h2, 7'(i), 8'(8'h10 + i)});
    end

    // Violations: rdn and wrn low together for 3 cycles, 300 times.
    wr_before = wr_log.size();
    rd_before = rd_cnt;
    for (int n = 0; n < 300; n++) begin
      bus.usb_rdn = 1'b0;
      bus.usb_wrn = 1'b0;
      tick();
      tick();
      tick();
      bus.usb_rdn = 1'b1;
      bus.usb_wrn = 1'b1;
      tick();
      if (n == 0) begin
        tick();
        check_eq("viol_one", bus.error_count, ErrAfterOne);
      end
    end
    tick();
    tick();
    check_eq("viol_errcnt", bus.error_count, ErrAfterAll);
    check_eq("viol_no_wr", wr_log.size(), wr_before);
    check_eq("viol_no_rd", rd_cnt, rd_before);
    check_eq("viol_idle", {bus.usb_isout, bus.reg_addrvalid}, 2'b00);

    // Reset while in WR_ARM; the cen pulse after release must not commit.
    wr_before = wr_log.size();
    bus.usb_addr = {14'h3, 7'd2};
    bus.usb_din  = 8'h77;
    bus.usb_wrn  = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rst_wrarm_outs", all_outs(), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    bus.usb_cen = 1'b0;
    tick();
    tick();
    tick();
    bus.usb_cen = 1'b1;
    tick();
    tick();
    check_eq("rst_wrarm_no_wr", wr_log.size(), wr_before);
    bus.usb_wrn = 1'b1;
    tick();
    tick();
    tick();

    // Reset while in RD_HOLD.
    bus.usb_addr = {14'h5, 7'd0};
    bus.usb_rdn  = 1'b0;
    bus.usb_cen  = 1'b0;
    tick();
    tick();
    tick();
    check_eq("rst_rdhold_pre", bus.usb_dout, 8'h3C);
    rd_before = rd_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("rst_rdhold_outs", all_outs(), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    tick();
    check_eq("rst_rdhold_no_rd", rd_cnt, rd_before);
    check_eq("rst_rdhold_isout", bus.usb_isout, 1'b0);
    bus.usb_rdn = 1'b1;
    bus.usb_cen = 1'b1;
    tick();
    tick();
    tick();

    // Normal operation resumes once the bus has gone idle.
    wr_before = wr_log.size();
    bus_write(14'h7F, 7'h7F, 8'hC3, 1'b0);
    check_eq("post_rst_wr_count", wr_log.size(), wr_before + 1);
    if (wr_log.size() > wr_before) check_eq("post_rst_wr_fields", wr_log[wr_before],
                                            {14'h7F, 7'h7F, 8'hC3});

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
